// File: rtl/osr_autopull.sv
// PIO output shift register with PULL/OUT handling and TX-FIFO valid/ready handshake.
// Optional background refill and autopull stall are enabled by defining OSR_AUTOPULL_EN.
module osr_autopull #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             penable_i,
  input  logic             restart_i,
  input  logic             dir_i,
  input  logic [SHW-1:0]   threshold_i,
  input  logic             autopull_en_i,
  input  logic             out_req_i,
  input  logic [SHW-1:0]   out_bits_i,
  input  logic             pull_req_i,
  input  logic             pull_block_i,
  input  logic             pull_ifempty_i,
  input  logic [WIDTH-1:0] x_data_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_valid_i,
  output logic             fifo_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  output logic             stall_o,
  output logic [SHW:0]     shift_count_o,
  output logic             empty_o
);

  localparam logic [SHW:0] WIDTH_C = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [SHW:0]     count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             active_s;
  logic             autopull_s;
  logic [SHW:0]     thresh_eff_s;
  logic [SHW:0]     n_s;
  logic [SHW:0]     lsh_s;
  logic [SHW+1:0]   sum_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] shifted_s;
  logic             pull_act_s;
  logic             pull_noop_s;
  logic             pull_fifo_s;
  logic             pull_stall_s;
  logic             pull_x_s;
  logic             out_go_s;
  logic             out_stall_s;
  logic             refill_s;

`ifdef OSR_AUTOPULL_EN
  assign autopull_s = autopull_en_i;
`else
  logic unused_s;
  assign unused_s   = autopull_en_i;
  assign autopull_s = 1'b0;
`endif

  // Effective threshold/bit count (field value 0 encodes a full WIDTH) and empty flag.
  always_comb begin
    thresh_eff_s = WIDTH_C;
    n_s          = WIDTH_C;
    if (threshold_i != {SHW{1'b0}}) begin
      thresh_eff_s = {1'b0, threshold_i};
    end else begin
      thresh_eff_s = WIDTH_C;
    end
    if (out_bits_i != {SHW{1'b0}}) begin
      n_s = {1'b0, out_bits_i};
    end else begin
      n_s = WIDTH_C;
    end
  end

  assign empty_o = (count_q >= thresh_eff_s);

  // Instruction arbitration: PULL wins over OUT; refill only without a PULL in flight.
  always_comb begin
    active_s     = penable_i & ~reset_i & ~restart_i;
    pull_act_s   = active_s & pull_req_i;
    pull_noop_s  = pull_ifempty_i & ~empty_o;
    pull_fifo_s  = pull_act_s & ~pull_noop_s & fifo_valid_i;
    pull_stall_s = pull_act_s & ~pull_noop_s & ~fifo_valid_i & pull_block_i;
    pull_x_s     = pull_act_s & ~pull_noop_s & ~fifo_valid_i & ~pull_block_i;
    out_go_s     = active_s & out_req_i & ~pull_req_i & ~(autopull_s & empty_o);
    out_stall_s  = active_s & out_req_i & (pull_req_i | (autopull_s & empty_o));
    refill_s     = active_s & autopull_s & empty_o & fifo_valid_i & ~pull_req_i;
  end

  assign stall_o      = pull_stall_s | out_stall_s;
  assign fifo_ready_o = pull_fifo_s | refill_s;

  // OUT datapath: right-aligned result and the shifted remainder, zeros shifted in.
  always_comb begin
    lsh_s     = WIDTH_C - n_s;
    mask_s    = ~({WIDTH{1'b1}} << n_s);
    result_s  = {WIDTH{1'b0}};
    shifted_s = {WIDTH{1'b0}};
    if (dir_i) begin
      result_s  = shift_reg_q & mask_s;
      shifted_s = shift_reg_q >> n_s;
    end else begin
      result_s  = shift_reg_q >> lsh_s;
      shifted_s = shift_reg_q << n_s;
    end
    sum_s = {1'b0, count_q} + {1'b0, n_s};
  end

  // Next-state selection for the shift register, count and OUT result.
  always_comb begin
    shift_reg_d = shift_reg_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (restart_i) begin
      count_d = WIDTH_C;
    end else if (pull_fifo_s || refill_s) begin
      shift_reg_d = fifo_data_i;
      count_d     = {(SHW+1){1'b0}};
    end else if (pull_x_s) begin
      shift_reg_d = x_data_i;
      count_d     = {(SHW+1){1'b0}};
    end else if (out_go_s) begin
      shift_reg_d = shifted_s;
      out_data_d  = result_s;
      out_valid_d = 1'b1;
      if (sum_s > {1'b0, WIDTH_C}) begin
        count_d = WIDTH_C;
      end else begin
        count_d = sum_s[SHW:0];
      end
    end else begin
      shift_reg_d = shift_reg_q;
    end
  end

  // State registers; penable low leaves everything but the out_valid pulse untouched.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shift_reg_q <= {WIDTH{1'b0}};
      count_q     <= WIDTH_C;
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      shift_reg_q <= shift_reg_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign shift_count_o = count_q;

endmodule

// File: tb/tb_osr_autopull.sv
// Directed self-checking bench for osr_autopull (WIDTH=32), default or OSR_AUTOPULL_EN build.
module tb_osr_autopull;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset;
  logic             penable;
  logic             restart;
  logic             dir;
  logic [SHW-1:0]   threshold;
  logic             autopull_en;
  logic             out_req;
  logic [SHW-1:0]   out_bits;
  logic             pull_req;
  logic             pull_block;
  logic             pull_ifempty;
  logic [WIDTH-1:0] x_data;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_valid;
  logic             fifo_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             stall;
  logic [SHW:0]     shift_count;
  logic             empty;

  int checks_cnt;
  int errors_cnt;

  osr_autopull #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .reset_i(reset), .penable_i(penable), .restart_i(restart),
    .dir_i(dir), .threshold_i(threshold), .autopull_en_i(autopull_en),
    .out_req_i(out_req), .out_bits_i(out_bits), .pull_req_i(pull_req),
    .pull_block_i(pull_block), .pull_ifempty_i(pull_ifempty), .x_data_i(x_data),
    .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid), .fifo_ready_o(fifo_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .stall_o(stall),
    .shift_count_o(shift_count), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_out(input logic d, input logic [SHW-1:0] bits);
    dir      = d;
    out_bits = bits;
    out_req  = 1'b1;
    step();
    out_req  = 1'b0;
  endtask

  task automatic do_pull_fifo(input logic [WIDTH-1:0] data);
    fifo_data  = data;
    fifo_valid = 1'b1;
    pull_req   = 1'b1;
    step();
    pull_req   = 1'b0;
    fifo_valid = 1'b0;
  endtask

  initial begin
    checks_cnt   = 0;
    errors_cnt   = 0;
    reset        = 1'b1;
    penable      = 1'b1;
    restart      = 1'b0;
    dir          = 1'b0;
    threshold    = 5'd0;
    autopull_en  = 1'b0;
    out_req      = 1'b0;
    out_bits     = 5'd0;
    pull_req     = 1'b0;
    pull_block   = 1'b0;
    pull_ifempty = 1'b0;
    x_data       = 32'h0;
    fifo_data    = 32'h0;
    fifo_valid   = 1'b0;
    step();
    step();
    check_val("rst_count", shift_count, 64'd32);
    check_val("rst_empty", empty, 64'd1);
    check_val("rst_outdata", out_data, 64'h0);
    check_val("rst_outvalid", out_valid, 64'd0);
    check_val("rst_stall", stall, 64'd0);
    check_val("rst_ready", fifo_ready, 64'd0);
    reset = 1'b0;
    step();

    // PULL from FIFO, then OUT 8 left
    fifo_data  = 32'hDEADBEEF;
    fifo_valid = 1'b1;
    pull_req   = 1'b1;
    #1;
    check_val("pull_ready", fifo_ready, 64'd1);
    check_val("pull_stall", stall, 64'd0);
    step();
    pull_req   = 1'b0;
    fifo_valid = 1'b0;
    #1;
    check_val("pull_count", shift_count, 64'd0);
    check_val("pull_ready_off", fifo_ready, 64'd0);
    do_out(1'b0, 5'd8);
    check_val("outl8_data", out_data, 64'hDE);
    check_val("outl8_valid", out_valid, 64'd1);
    check_val("outl8_count", shift_count, 64'd8);
    step();
    check_val("outl8_pulse_end", out_valid, 64'd0);
    check_val("outl8_hold", out_data, 64'hDE);

    // Right shifts of 4, back to back
    do_pull_fifo(32'h12345678);
    dir = 1'b1; out_bits = 5'd4; out_req = 1'b1;
    step();
    check_val("outr4_a", out_data, 64'h8);
    check_val("outr4_va", out_valid, 64'd1);
    step();
    check_val("outr4_b", out_data, 64'h7);
    check_val("outr4_vb", out_valid, 64'd1);
    step();
    check_val("outr4_c", out_data, 64'h6);
    check_val("outr4_vc", out_valid, 64'd1);
    check_val("outr4_count", shift_count, 64'd12);
    out_req = 1'b0;

    // Full-width OUT saturates count, then OUT at count=WIDTH shifts zeros without stall
    do_out(1'b1, 5'd0);
    check_val("outr32_data", out_data, 64'h00012345);
    check_val("outr32_count", shift_count, 64'd32);
    out_req = 1'b1; out_bits = 5'd8;
    #1;
    check_val("out_full_nostall", stall, 64'd0);
    step();
    out_req = 1'b0;
    check_val("out_full_zero", out_data, 64'h0);
    check_val("out_full_valid", out_valid, 64'd1);
    check_val("out_full_count", shift_count, 64'd32);

`ifdef OSR_AUTOPULL_EN
    autopull_en = 1'b1;
    dir = 1'b0; out_bits = 5'd0; out_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("ap_stall", stall, 64'd1);
      check_val("ap_noready", fifo_ready, 64'd0);
      step();
    end
    fifo_data  = 32'hA5A5A5A5;
    fifo_valid = 1'b1;
    #1;
    check_val("ap_refill_ready", fifo_ready, 64'd1);
    check_val("ap_refill_stall", stall, 64'd1);
    step();
    fifo_valid = 1'b0;
    check_val("ap_count_zero", shift_count, 64'd0);
    check_val("ap_stall_off", stall, 64'd0);
    step();
    out_req = 1'b0;
    check_val("ap_data", out_data, 64'hA5A5A5A5);
    check_val("ap_valid", out_valid, 64'd1);
    check_val("ap_count", shift_count, 64'd32);
    autopull_en = 1'b0;
`else
    autopull_en = 1'b1;
    fifo_data   = 32'hA5A5A5A5;
    fifo_valid  = 1'b1;
    dir = 1'b0; out_bits = 5'd0; out_req = 1'b1;
    #1;
    check_val("noap_stall", stall, 64'd0);
    check_val("noap_ready", fifo_ready, 64'd0);
    step();
    out_req    = 1'b0;
    fifo_valid = 1'b0;
    check_val("noap_valid", out_valid, 64'd1);
    check_val("noap_data", out_data, 64'h0);
    check_val("noap_count", shift_count, 64'd32);
    autopull_en = 1'b0;
`endif

    // Blocking PULL on empty FIFO, then non-blocking PULL loads X
    pull_req = 1'b1; pull_block = 1'b1; fifo_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("blk_stall", stall, 64'd1);
      check_val("blk_ready", fifo_ready, 64'd0);
      step();
    end
    check_val("blk_count", shift_count, 64'd32);
    pull_block = 1'b0;
    x_data     = 32'h55;
    #1;
    check_val("nb_stall", stall, 64'd0);
    step();
    pull_req = 1'b0;
    check_val("nb_count", shift_count, 64'd0);
    do_out(1'b1, 5'd8);
    check_val("nb_data", out_data, 64'h55);

    // PULL if-empty below threshold is a no-op and stalls a concurrent OUT
    do_pull_fifo(32'hCAFEF00D);
    do_out(1'b0, 5'd4);
    check_val("ife_pre_data", out_data, 64'hC);
    threshold    = 5'd16;
    pull_ifempty = 1'b1;
    pull_req     = 1'b1;
    out_req      = 1'b1;
    fifo_valid   = 1'b1;
    fifo_data    = 32'h11111111;
    #1;
    check_val("ife_empty", empty, 64'd0);
    check_val("ife_ready", fifo_ready, 64'd0);
    check_val("ife_out_stall", stall, 64'd1);
    step();
    pull_req = 1'b0; out_req = 1'b0; fifo_valid = 1'b0; pull_ifempty = 1'b0;
    check_val("ife_count", shift_count, 64'd4);
    check_val("ife_novalid", out_valid, 64'd0);
    do_out(1'b0, 5'd4);
    check_val("ife_kept", out_data, 64'hA);

    // Restart: count to WIDTH, shift_reg and out_data kept
    restart = 1'b1; out_req = 1'b1; pull_req = 1'b1; fifo_valid = 1'b1;
    #1;
    check_val("rs_ready", fifo_ready, 64'd0);
    check_val("rs_stall", stall, 64'd0);
    step();
    restart = 1'b0; out_req = 1'b0; pull_req = 1'b0; fifo_valid = 1'b0;
    check_val("rs_count", shift_count, 64'd32);
    check_val("rs_valid", out_valid, 64'd0);
    check_val("rs_data", out_data, 64'hA);
    threshold = 5'd0;
    do_out(1'b0, 5'd4);
    check_val("rs_kept", out_data, 64'hF);

    // penable low freezes state
    penable = 1'b0; out_req = 1'b1; pull_req = 1'b1; pull_block = 1'b1; fifo_valid = 1'b1;
    #1;
    check_val("pe_stall", stall, 64'd0);
    check_val("pe_ready", fifo_ready, 64'd0);
    step();
    step();
    check_val("pe_count", shift_count, 64'd32);
    check_val("pe_valid", out_valid, 64'd0);
    check_val("pe_data", out_data, 64'hF);
    penable = 1'b1; pull_req = 1'b0; pull_block = 1'b0; fifo_valid = 1'b0; out_req = 1'b0;
    do_out(1'b0, 5'd4);
    check_val("pe_kept", out_data, 64'hE);

    // Async reset in the middle of a PULL
    fifo_data = 32'h77777777; fifo_valid = 1'b1; pull_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_ready", fifo_ready, 64'd0);
    check_val("arst_count", shift_count, 64'd32);
    check_val("arst_data", out_data, 64'h0);
    step();
    reset = 1'b0; pull_req = 1'b0; fifo_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/osr_autopull.md
# osr_autopull

Parametrised PIO output shift register with integrated autopull and TX-FIFO handshake, replacing the fixed 32-bit OSR in each state machine. Takes data from the TX FIFO on a valid/ready interface, either through explicit PULL (blocking/non-blocking, if-empty) or automatic refill on a programmable threshold. Serves OUT instructions of 1..WIDTH bits in either direction with a registered, right-aligned output, and raises stall to the instruction decoder when an operation cannot complete.

## Interface
Parameters:
- WIDTH, 32, shift register width; power of two, 8..64.
- SHW, $clog2(WIDTH), width of shift/threshold fields (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- penable  in  1  clock-divider enable; no state changes when low.
- restart  in  1  synchronous SM restart: count set to WIDTH (empty), shift_reg kept.
- dir  in  1  0 = shift left (MSB out), 1 = shift right (LSB out).
- threshold  in  SHW  autopull threshold in bits; 0 means WIDTH.
- autopull_en  in  1  enable background refill.
- out_req  in  1  OUT instruction present this cycle.
- out_bits  in  SHW  OUT bit count; 0 means WIDTH.
- pull_req  in  1  PULL instruction present.
- pull_block  in  1  PULL blocks when FIFO empty.
- pull_ifempty  in  1  PULL is a no-op unless count >= threshold.
- x_data  in  WIDTH  scratch X, loaded by non-blocking PULL on empty FIFO.
- fifo_data  in  WIDTH  TX FIFO head.
- fifo_valid  in  1  TX FIFO not empty.
- fifo_ready  out  1  pop strobe, combinational.
- out_data  out  WIDTH  registered, right-aligned OUT result, upper bits zero.
- out_valid  out  1  one-cycle pulse with out_data.
- stall  out  1  current instruction not completed, combinational.
- shift_count  out  SHW+1  bits consumed, 0..WIDTH.
- empty  out  1  shift_count >= effective threshold.

## Operation
- "Active cycle" = penable high and reset/restart low; outside active cycles fifo_ready=0, stall=0, out_valid=0, state held.
- Load: shift_reg <= source, count <= 0.
- Priority per active cycle: pull_req > out_req; when both high, PULL executes and out_req is stalled.
- PULL: if pull_ifempty and !empty: complete, no change. Else fifo_valid: load fifo_data, fifo_ready=1. Else pull_block: stall=1. Else load x_data.
- OUT with autopull_en=1 and empty=1: stall=1, no shift; refill happens the same cycle if fifo_valid.
- OUT otherwise (n = out_bits, 0 -> WIDTH): left: result = top n bits of shift_reg, shift_reg <<= n; right: result = low n bits, shift_reg >>= n; vacated bits 0; n = WIDTH clears shift_reg; count <= min(count+n, WIDTH).
- Background refill: autopull_en, empty, fifo_valid, no PULL this cycle -> load fifo_data, fifo_ready=1, independent of out_req.
- OUT with autopull_en=0 never stalls, even at count = WIDTH (shifts zeros).
- out_data updates only on completed OUT; holds otherwise.
- restart: count <= WIDTH; shift_reg, out_data kept; out_valid <= 0; fifo_ready=0.

## Timing
- Reset values: shift_reg 0, count WIDTH, out_data 0, out_valid 0; thus empty=1, fifo_ready=0, stall=0.
- OUT completed at edge N: out_data/out_valid visible after edge N, pulse lasts one cycle; back-to-back OUTs give continuous out_valid.
- Stalled OUT with autopull: refill at edge N, OUT completes at edge N+1 (earliest).
- OUT that makes count >= threshold: refill at the following active cycle if fifo_valid.
- fifo_ready is asserted only when fifo_valid is high, at most once per cycle; FIFO pops on clk edge.
- Reset asserted mid-OUT or mid-refill: immediate reset values; no pop counted.

## Configuration
- OSR_AUTOPULL_EN defined: background refill and autopull stall as above.
- Undefined: autopull_en ignored (treated 0), no refill logic; fifo_ready asserted only by PULL; OUT never stalls.

## Test plan
- Reset, then PULL with fifo_valid, fifo_data=0xDEADBEEF: fifo_ready=1 one cycle, shift_count=0; OUT 8 left -> out_data=0x000000DE, shift_count=8.
- dir=1, OUT 4 x3 on 0x12345678: out_data 0x8, 0x7, 0x6; shift_count 12; out_valid high 3 cycles.
- autopull_en=1, threshold=0, FIFO empty, OUT 32 after full drain: stall held; fifo_valid rises with 0xA5A5A5A5 -> load, OUT completes next cycle, out_data=0xA5A5A5A5.
- Blocking PULL, FIFO empty 5 cycles: stall=1 for 5 cycles, fifo_ready=0; non-blocking PULL loads x_data=0x55, shift_count=0.
- pull_ifempty with shift_count=4, threshold=16: no pop, no stall; restart mid-stream -> shift_count=32, shift_reg kept.
- penable low with out_req/pull_req high: no state change, stall=0, fifo_ready=0.
